// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold/release protocol and forced
// pre-emption after MAX_HOLD cycles. Optional grant counter under RR_ARB_STATS_EN.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
`ifdef RR_ARB_STATS_EN
  ,
  output logic [15:0]        grant_count
`endif
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned CandW = ID_W + 1;

  typedef enum logic {StIdle, StOwned} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
`ifdef RR_ARB_STATS_EN
  logic [15:0]        grant_count_q, grant_count_d;
`endif

  logic               sel_found;
  logic [ID_W-1:0]    sel_idx;
  logic [CandW-1:0]   cand;
  logic               release_cond;

  assign any_req = |req;

  // First set request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = CandW'({1'b0, ptr_q}) + CandW'(i);
      if (cand >= CandW'(NUM_REQ)) begin
        cand = cand - CandW'(NUM_REQ);
      end
      if (!sel_found && req[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign release_cond = done || !req[grant_id_q] || (hold_cnt_q == HoldW'(MAX_HOLD - 1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
`ifdef RR_ARB_STATS_EN
    grant_count_d = grant_count_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d       = StOwned;
          grant_d       = NUM_REQ'(1) << sel_idx;
          grant_valid_d = 1'b1;
          grant_id_d    = sel_idx;
          hold_cnt_d    = '0;
`ifdef RR_ARB_STATS_EN
          if (grant_count_q != 16'hFFFF) begin
            grant_count_d = grant_count_q + 16'd1;
          end
`endif
        end
      end
      StOwned: begin
        if (release_cond) begin
          state_d       = StIdle;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          ptr_d         = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
`ifdef RR_ARB_STATS_EN
      grant_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
`ifdef RR_ARB_STATS_EN
      grant_count_q <= grant_count_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
`ifdef RR_ARB_STATS_EN
  assign grant_count = grant_count_q;
`endif

endmodule
